// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
// Imported by shift_add_mult_16b.
package mult_pkg;

  localparam int MULT_N     = 16;
  localparam int MULT_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla_16b.sv
// 16-bit two-level carry-lookahead adder (4x4-bit groups).
// Ports: a, b [15:0], c_in in; sum [15:0], c_out out.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g, p;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (&p[4*k+2 +: 2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
  end

  // Group carries are fully expanded so no group waits on another.
  always_comb begin
    cg[0] = c_in;
    cg[1] = gg[0] | (pg[0] & c_in);
    cg[2] = gg[1] | (pg[1] & gg[0])
          | (&pg[1:0] & c_in);
    cg[3] = gg[2] | (pg[2] & gg[1])
          | (&pg[2:1] & gg[0])
          | (&pg[2:0] & c_in);
    cg[4] = gg[3] | (pg[3] & gg[2])
          | (&pg[3:2] & gg[1])
          | (&pg[3:1] & gg[0])
          | (&pg[3:0] & c_in);
  end

  always_comb begin
    logic cc;
    cc  = 1'b0;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      cc = cg[k];
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ cc;
        cc = g[4*k+j] | (p[4*k+j] & cc);
      end
    end
  end

  assign c_out = cg[4];

endmodule

// File: rtl/dff_srn.sv
// Generic register with synchronous active-low reset to zero.
// Ports: clk, rst_n, d[W-1:0] in; q[W-1:0] out.
module dff_srn #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/shift_add_mult_16b.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier, 1 bit/cycle.
// Ports: clk, rst_n, start, a, b in; busy, done, product out.
module shift_add_mult_16b
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [1:0]     st_q;
  state_t         st_d;
  logic [N-1:0]   m_q, m_d;
  logic [2*N-1:0] p_q, p_d, p_shift;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   sum;
  logic           c_out;

  cla_16b ADDER (
    .a     (p_q[2*N-1:N]),
    .b     (m_q),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Add the multiplicand into the upper half when the LSB is set,
  // then shift the whole accumulator right, carry included.
  assign p_shift = p_q[0]
    ? {c_out, sum, p_q[N-1:1]}
    : {1'b0, p_q[2*N-1:N], p_q[N-1:1]};

  always_comb begin
    st_d  = state_t'(st_q);
    m_d   = m_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    case (st_q)
      RUN: begin
        p_d   = p_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(MULT_ITERS - 1))
          st_d = DONE;
      end
      // IDLE, DONE and the unused code all behave as IDLE.
      default: begin
        st_d = IDLE;
        if (start) begin
          m_d   = a;
          p_d   = {{N{1'b0}}, b};
          cnt_d = '0;
          st_d  = RUN;
        end
      end
    endcase
  end

  dff_srn #(.W(2)) u_st (
    .clk(clk), .rst_n(rst_n), .d(st_d), .q(st_q)
  );

  dff_srn #(.W(N)) u_m (
    .clk(clk), .rst_n(rst_n), .d(m_d), .q(m_q)
  );

  dff_srn #(.W(2*N)) u_p (
    .clk(clk), .rst_n(rst_n), .d(p_d), .q(p_q)
  );

  dff_srn #(.W(4)) u_cnt (
    .clk(clk), .rst_n(rst_n), .d(cnt_d), .q(cnt_q)
  );

  assign busy    = (st_q == RUN);
  assign done    = (st_q == DONE);
  assign product = p_q;

endmodule

// File: tb/tb_shift_add_mult_16b.sv
// Scoreboard bench for shift_add_mult_16b: directed cases plus
// random operand pairs checked against plain a*b arithmetic.
module tb_shift_add_mult_16b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  shift_add_mult_16b dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", product, e.exp);
          chk("latency", cyc - e.acc, 16);
        end
      end
    end
  end

  // Called at a negedge with the DUT in IDLE or DONE; leaves start high.
  task automatic issue(input logic [15:0] x,
                       input logic [15:0] y);
    exp_t e;
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.exp = 32'(x) * 32'(y);
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done(output int nbusy);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int nb;
    int c1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_product", product, 0);
    mon_en = 1'b1;

    // 3 * 5 with busy-length check
    issue(16'h0003, 16'h0005);
    start = 1'b0;
    wait_done(nb);
    chk("3x5_busy_cycles", nb, 16);
    chk("3x5_value", product, 32'h0000000F);
    @(negedge clk);
    chk("idle_after_done", 32'({busy, done}), 0);
    chk("hold_product", product, 32'h0000000F);

    issue(16'hFFFF, 16'hFFFF);
    start = 1'b0;
    wait_done(nb);
    chk("ffff_sq", product, 32'hFFFE0001);
    @(negedge clk);

    issue(16'h0000, 16'h1234);
    start = 1'b0;
    wait_done(nb);
    chk("zero_mul", product, 32'h0);
    @(negedge clk);

    // start pulse during RUN must be ignored
    issue(16'h1234, 16'h5678);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = 16'h0002;
    b = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    chk("ignore_start", product, 32'h06260060);
    repeat (20) @(negedge clk);

    // reset mid-run aborts without done
    issue(16'h1234, 16'h5678);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_product", product, 0);
    repeat (20) @(negedge clk);
    issue(16'd7, 16'd9);
    start = 1'b0;
    wait_done(nb);
    chk("7x9", product, 32'h3F);
    @(negedge clk);

    // back-to-back with start held
    issue(16'h8000, 16'h0002);
    wait_done(nb);
    chk("b2b_first", product, 32'h00010000);
    c1 = cyc;
    issue(16'h00FF, 16'h0101);
    chk("b2b_no_bubble", 32'(busy), 1);
    start = 1'b0;
    wait_done(nb);
    chk("b2b_second", product, 32'h0000FFFF);
    chk("b2b_spacing", cyc - c1, 17);
    @(negedge clk);

    // random pairs, some issued back-to-back
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 3))
        0: x = 16'hFFFF;
        1: y = 16'($urandom_range(0, 3));
        default: ;
      endcase
      issue(x, y);
      wait_done(nb);
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
